// File: rtl/reg_bank_if.sv
// reg_bank_if
// Control/bus bundle feeding the destination register bank.
//   busin   : 16-bit shared bus value (output of the bus source mux)
//   write   : 5-bit destination select (0 = no write)
//   inc_sel : 3-bit increment target select
//   clr_sel : 2-bit clear target select (index counters only)
//   acc_en  : accumulate strobe, AC <= AC + busin
// The master modport belongs to the control unit / bus mux side.
// The slave modport belongs to the register bank.
interface reg_bank_if;
    logic [15:0] busin;
    logic [4:0]  write;
    logic [2:0]  inc_sel;
    logic [1:0]  clr_sel;
    logic        acc_en;

    modport master (
        output busin,
        output write,
        output inc_sel,
        output clr_sel,
        output acc_en
    );

    modport slave (
        input busin,
        input write,
        input inc_sel,
        input clr_sel,
        input acc_en
    );
endinterface

// File: rtl/reg_bank.sv
// reg_bank
// Destination register bank of the matrix-multiplication datapath.
// Each cycle it may do all of the following on different registers:
//   - load one register from the shared bus,
//   - clear one index counter,
//   - increment one counter or address register,
//   - accumulate the bus into AC.
// When several operations target the same register, write wins over
// clear, and clear wins over increment. A write to AC wins over acc_en.
// Ports:
//   clock, resetn : rising-edge clock and asynchronous active-low reset
//   ctl           : bus value and control strobes (reg_bank_if.slave)
//   IR..DAR       : 8-bit architectural registers
//   TAC, R, AC    : 16-bit architectural registers
//   end_i/j/k     : combinational loop-terminate flags (counter == size)
module reg_bank (
    input  logic        clock,
    input  logic        resetn,
    reg_bank_if.slave   ctl,
    output logic [7:0]  IR,
    output logic [7:0]  PC,
    output logic [7:0]  AR,
    output logic [7:0]  DAR,
    output logic [7:0]  CI,
    output logic [7:0]  CJ,
    output logic [7:0]  CK,
    output logic [7:0]  SI,
    output logic [7:0]  SJ,
    output logic [7:0]  SK,
    output logic [7:0]  AA,
    output logic [7:0]  AB,
    output logic [7:0]  AD,
    output logic [15:0] TAC,
    output logic [15:0] R,
    output logic [15:0] AC,
    output logic        end_i,
    output logic        end_j,
    output logic        end_k
);

    localparam logic [4:0] W_IR  = 5'd3;
    localparam logic [4:0] W_PC  = 5'd4;
    localparam logic [4:0] W_TAC = 5'd5;
    localparam logic [4:0] W_R   = 5'd6;
    localparam logic [4:0] W_CI  = 5'd7;
    localparam logic [4:0] W_CJ  = 5'd8;
    localparam logic [4:0] W_CK  = 5'd9;
    localparam logic [4:0] W_AA  = 5'd10;
    localparam logic [4:0] W_AB  = 5'd11;
    localparam logic [4:0] W_AD  = 5'd12;
    localparam logic [4:0] W_SI  = 5'd13;
    localparam logic [4:0] W_SJ  = 5'd14;
    localparam logic [4:0] W_SK  = 5'd15;
    localparam logic [4:0] W_AC  = 5'd16;
    localparam logic [4:0] W_AR  = 5'd17;
    localparam logic [4:0] W_DAR = 5'd18;

    logic [7:0] bus_lo;
    logic       inc_pc, inc_ci, inc_cj, inc_ck, inc_ar, inc_dar;
    logic       clr_ci, clr_cj, clr_ck;

    // Decode the increment and clear selects into per-register strobes.
    // inc_sel codes 0 and 7 decode to nothing.
    always_comb begin
        bus_lo  = ctl.busin[7:0];
        inc_pc  = (ctl.inc_sel == 3'd1);
        inc_ci  = (ctl.inc_sel == 3'd2);
        inc_cj  = (ctl.inc_sel == 3'd3);
        inc_ck  = (ctl.inc_sel == 3'd4);
        inc_ar  = (ctl.inc_sel == 3'd5);
        inc_dar = (ctl.inc_sel == 3'd6);
        clr_ci  = (ctl.clr_sel == 2'd1);
        clr_cj  = (ctl.clr_sel == 2'd2);
        clr_ck  = (ctl.clr_sel == 2'd3);
    end

    // Load-only registers. The 8-bit ones keep the low byte of the bus.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            IR  <= 8'h00;
            AA  <= 8'h00;
            AB  <= 8'h00;
            AD  <= 8'h00;
            SI  <= 8'h00;
            SJ  <= 8'h00;
            SK  <= 8'h00;
            TAC <= 16'h0000;
            R   <= 16'h0000;
        end else begin
            if (ctl.write == W_IR)  IR  <= bus_lo;
            if (ctl.write == W_AA)  AA  <= bus_lo;
            if (ctl.write == W_AB)  AB  <= bus_lo;
            if (ctl.write == W_AD)  AD  <= bus_lo;
            if (ctl.write == W_SI)  SI  <= bus_lo;
            if (ctl.write == W_SJ)  SJ  <= bus_lo;
            if (ctl.write == W_SK)  SK  <= bus_lo;
            if (ctl.write == W_TAC) TAC <= ctl.busin;
            if (ctl.write == W_R)   R   <= ctl.busin;
        end
    end

    // Incrementing address registers: a bus load takes precedence over
    // the increment. The 8-bit add wraps 255 -> 0 naturally.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            PC  <= 8'h00;
            AR  <= 8'h00;
            DAR <= 8'h00;
        end else begin
            if (ctl.write == W_PC)       PC  <= bus_lo;
            else if (inc_pc)             PC  <= PC + 8'd1;
            if (ctl.write == W_AR)       AR  <= bus_lo;
            else if (inc_ar)             AR  <= AR + 8'd1;
            if (ctl.write == W_DAR)      DAR <= bus_lo;
            else if (inc_dar)            DAR <= DAR + 8'd1;
        end
    end

    // Matrix index counters: load, then clear, then increment.
    // Every branch reads the pre-edge value, so a bus read of the
    // counter combined with its own write simply reloads it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            CI <= 8'h00;
            CJ <= 8'h00;
            CK <= 8'h00;
        end else begin
            if (ctl.write == W_CI)       CI <= bus_lo;
            else if (clr_ci)             CI <= 8'h00;
            else if (inc_ci)             CI <= CI + 8'd1;
            if (ctl.write == W_CJ)       CJ <= bus_lo;
            else if (clr_cj)             CJ <= 8'h00;
            else if (inc_cj)             CJ <= CJ + 8'd1;
            if (ctl.write == W_CK)       CK <= bus_lo;
            else if (clr_ck)             CK <= 8'h00;
            else if (inc_ck)             CK <= CK + 8'd1;
        end
    end

    // Accumulator: a direct load beats accumulation; the sum drops the
    // carry out of bit 15.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            AC <= 16'h0000;
        end else if (ctl.write == W_AC) begin
            AC <= ctl.busin;
        end else if (ctl.acc_en) begin
            AC <= AC + ctl.busin;
        end
    end

    // Loop-terminate flags look at the live register outputs.
    assign end_i = (CI == SI);
    assign end_j = (CJ == SJ);
    assign end_k = (CK == SK);

endmodule
